cnt_desc_mod7_btn: RTL and testbench

Descending modulo-7 counter (6, 5, 4, 3, 2, 1, 0, 6, …) advanced by a debounced pushbutton or a direct decrement tick.
- Provides a synchronous load and a wrap/borrow pulse for cascading.
- Drives the board LEDs directly.
- It is the count-down counterpart of the ascending mod-7 LED counter and lives in the same board-level demo designs.

---
 rtl/cnt_desc_mod7_btn.sv | 120 ++++++++++++
 tb/tb_cnt_desc_mod7_btn.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cnt_desc_mod7_btn.sv
// Descending mod-7 LED counter (6..0, wrap to 6), stepped by a debounced button or a dec tick.
// Load has priority over both step sources. borrow is a registered one-cycle wrap pulse.
module cnt_desc_mod7_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       dec,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] led,
  output logic       borrow,
  output logic       btn_db
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_t;

  db_state_t     state, state_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic          s1, btn_s;
  logic          step;
  logic [2:0]    q, q_dec, q_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn;
      btn_s <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RELEASED;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // step fires only on the PRESS_CHK -> PRESSED transition, so a held button counts once
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    step     = 1'b0;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nx = PRESS_CHK;
          dcnt_nx  = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_nx = RELEASED;
        end else if (dcnt == DMAX) begin
          state_nx = PRESSED;
          step     = 1'b1;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nx = RELEASE_CHK;
          dcnt_nx  = '0;
        end
      end
      RELEASE_CHK: begin
        if (btn_s) begin
          state_nx = PRESSED;
        end else if (dcnt == DMAX) begin
          state_nx = RELEASED;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      default: begin
        state_nx = RELEASED;
        dcnt_nx  = '0;
      end
    endcase
  end

  assign btn_db = (state == PRESSED) || (state == RELEASE_CHK);

  // an illegal 7 (upset) decrements straight to 6, same as a wrap but without borrow
  assign q_dec  = ((q == 3'd0) || (q == 3'd7)) ? 3'd6 : q - 3'd1;
  assign q_load = (load_val == 3'd7) ? 3'd6 : load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= 3'd6;
      borrow <= 1'b0;
    end else if (load) begin
      q      <= q_load;
      borrow <= 1'b0;
    end else if (step || dec) begin
      q      <= q_dec;
      borrow <= (q == 3'd0);
    end else begin
      borrow <= 1'b0;
    end
  end

  assign led = q;

endmodule

// File: tb/tb_cnt_desc_mod7_btn.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor pops and compares.
module tb_cnt_desc_mod7_btn;

  logic       clk;
  logic       reset;
  logic       btn;
  logic       dec;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] led;
  logic       borrow;
  logic       btn_db;

  cnt_desc_mod7_btn #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .dec      (dec),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .borrow   (borrow),
    .btn_db   (btn_db)
  );

  typedef struct {
    logic [2:0] led;
    logic       brw;
    logic       db;
    logic [2:0] m;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;
  event chk_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic push(input logic [2:0] l, input logic b, input logic d, input logic [2:0] m);
    exp_t e;
    e.led = l;
    e.brw = b;
    e.db  = d;
    e.m   = m;
    e.tag = tag;
    tag++;
    q.push_back(e);
  endtask

  // drive one cycle of inputs and record what the outputs must be after the next edge
  task automatic cyc(input logic idec, input logic iload, input logic [2:0] lv, input logic ibtn,
                     input logic [2:0] l, input logic b, input logic d);
    @(negedge clk);
    dec      = idec;
    load     = iload;
    load_val = lv;
    btn      = ibtn;
    push(l, b, d, 3'b111);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    reset = 1'b1;
    dec   = 1'b0;
    load  = 1'b0;
    btn   = 1'b0;
    push(3'd6, 1'b0, 1'b0, 3'b111);
    -> chk_ev;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.m[2]) begin
          checks++;
          if (led !== e.led) begin
            errors++;
            $display("FAIL led vec %0d got %0d want %0d", e.tag, led, e.led);
          end
        end
        if (e.m[1]) begin
          checks++;
          if (borrow !== e.brw) begin
            errors++;
            $display("FAIL borrow vec %0d got %0b want %0b", e.tag, borrow, e.brw);
          end
        end
        if (e.m[0]) begin
          checks++;
          if (btn_db !== e.db) begin
            errors++;
            $display("FAIL btn_db vec %0d got %0b want %0b", e.tag, btn_db, e.db);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] seq [7];
    logic [2:0] m;
    logic       b;
    seq = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd6};
    reset = 1'b1; btn = 1'b0; dec = 1'b0; load = 1'b0; load_val = 3'd0;

    // reset state and seven dec pulses through the wrap
    rst_pulse();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 3'd0, 1'b0, seq[i], (i == 6), 1'b0);
      cyc(1'b0, 1'b0, 3'd0, 1'b0, seq[i], 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd4, 1'b0, 1'b0);
    rst_pulse();
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0);

    // loads, coercion of 7, load beating dec, load 0 -> 6 without borrow
    cyc(1'b0, 1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd7, 1'b0, 3'd6, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd6, 1'b0, 3'd6, 1'b0, 1'b0);

    // back-to-back dec: wrap every 7th cycle
    m = 3'd6;
    for (int i = 0; i < 14; i++) begin
      b = (m == 3'd0);
      m = (m == 3'd0) ? 3'd6 : m - 3'd1;
      cyc(1'b1, 1'b0, 3'd0, 1'b0, m, b, 1'b0);
    end
    cyc(1'b0, 1'b0, 3'd0, 1'b0, m, 1'b0, 1'b0);

    // held button: one step at edge 7, btn_db falls 7 edges after release
    cyc(1'b0, 1'b1, 3'd6, 1'b0, 3'd6, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++)
      cyc(1'b0, 1'b0, 3'd0, 1'b1, (i >= 7) ? 3'd5 : 3'd6, 1'b0, (i >= 7));
    for (int i = 1; i <= 10; i++)
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, (i < 7));

    // glitches of 1..4 cycles are rejected
    for (int w = 1; w <= 4; w++) begin
      for (int i = 0; i < w; i++)
        cyc(1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++)
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0);
    end
    // five high samples is the shortest accepted press
    for (int i = 1; i <= 14; i++)
      cyc(1'b0, 1'b0, 3'd0, (i <= 5), (i >= 7) ? 3'd4 : 3'd5, 1'b0, (i >= 7 && i <= 11));

    // release bounce: low 2, high 1, low 10 after a press to 4
    cyc(1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0);
    for (int i = 1; i <= 26; i++)
      cyc(1'b0, 1'b0, 3'd0, (i <= 10) || (i == 13), (i >= 7) ? 3'd4 : 3'd5, 1'b0,
          (i >= 7 && i <= 19));

    // debounced step coincides with dec at 0: single wrap
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++)
      cyc((i == 7), 1'b0, 3'd0, (i <= 8), (i >= 7) ? 3'd6 : 3'd0, (i == 7),
          (i >= 7 && i <= 14));

    cyc(1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
